zap_mem_burst_unit: RTL and testbench

Bus-side counterpart to the decode-stage LDM/STM sequencer. It accepts the single-word LDR/STR micro-ops from the memory stage and issues them on a Wishbone B3 registered-feedback master port. Micro-ops of one multiple-transfer sequence share a single bus cycle (CYC held), and incrementing sequences are tagged as incrementing bursts. On a bus error it returns an abort and discards the rest of the sequence; the base-restore micro-op then undoes writeback.

---
 rtl/zap_mem_burst_unit_pkg.sv | 41 ++++
 rtl/zap_mem_burst_unit.sv | 180 ++++++++++++++++++
 tb/tb_zap_mem_burst_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_mem_burst_unit_pkg.sv
// Shared constants, state encoding and beat payload for the ZAP memory burst unit.
package zap_mem_burst_unit_pkg;

    localparam int unsigned MAX_BEATS_DEF = 16;
    localparam int unsigned ADR_W         = 32;
    localparam int unsigned DAT_W         = 32;
    localparam int unsigned SEL_W         = 4;
    localparam int unsigned CTI_W         = 3;
    localparam int unsigned BTE_W         = 2;

    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic             we;
    } wb_beat_t;

    // burst_open: an incrementing burst is in progress and this beat must close or extend it.
    function automatic logic [CTI_W-1:0] beat_cti(input logic seq, input logic incr,
                                                  input logic burst_open, input logic at_max);
        if (seq && incr && !at_max) begin
            return CTI_INCR;
        end
        if ((seq && incr) || burst_open) begin
            return CTI_EOB;
        end
        return CTI_CLASSIC;
    endfunction

endpackage

// File: rtl/zap_mem_burst_unit.sv
// Issues LDR/STR micro-ops on a Wishbone B3 registered-feedback master port,
// holding CYC across a multiple-transfer sequence and tagging incrementing bursts.
module zap_mem_burst_unit
    import zap_mem_burst_unit_pkg::*;
#(
    parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [ADR_W-1:0] i_req_addr,
    input  logic             i_req_wen,
    input  logic [DAT_W-1:0] i_req_data,
    input  logic [SEL_W-1:0] i_req_ben,
    input  logic             i_req_seq,
    input  logic             i_req_incr,
    output logic             o_rsp_valid,
    output logic [DAT_W-1:0] o_rsp_data,
    output logic             o_rsp_abort,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [ADR_W-1:0] o_wb_adr,
    output logic [DAT_W-1:0] o_wb_dat,
    output logic [SEL_W-1:0] o_wb_sel,
    output logic [CTI_W-1:0] o_wb_cti,
    output logic [BTE_W-1:0] o_wb_bte,
    input  logic             i_wb_ack,
    input  logic             i_wb_err,
    input  logic [DAT_W-1:0] i_wb_dat
);

    localparam int unsigned      CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               in_incr_q, in_incr_d;
    logic               seq_q, seq_d;
    wb_beat_t           beat_q, beat_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic [CTI_W-1:0]   cti_q, cti_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_abort_q, rsp_abort_d;
    logic [DAT_W-1:0]   rsp_data_q, rsp_data_d;
    logic               accept;
    logic               unused_addr_lsb;

    // Byte offset travels on i_req_ben; the bus address is word aligned.
    assign unused_addr_lsb = ^i_req_addr[1:0];

    assign o_req_ready = (state_q != ST_BUS);
    assign accept      = i_req_valid && o_req_ready;

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        in_incr_d   = in_incr_q;
        seq_d       = seq_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        cti_d       = cti_q;
        rsp_valid_d = 1'b0;
        rsp_abort_d = rsp_abort_q;
        rsp_data_d  = rsp_data_q;

        if (i_flush) begin
            state_d    = ST_IDLE;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            beat_cnt_d = '0;
            in_incr_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        beat_d  = '{adr: {i_req_addr[ADR_W-1:2], 2'b00},
                                    dat: i_req_data,
                                    sel: i_req_ben,
                                    we:  i_req_wen};
                        seq_d   = i_req_seq;
                        cti_d   = beat_cti(i_req_seq, i_req_incr, in_incr_q,
                                           beat_cnt_q == LAST_CNT);
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        state_d = ST_BUS;
                        // A full burst restarts the count even if the sequence continues.
                        if (!i_req_seq || (beat_cnt_q == LAST_CNT)) begin
                            beat_cnt_d = '0;
                            in_incr_d  = 1'b0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                            in_incr_d  = i_req_incr;
                        end
                    end
                end
                ST_BUS: begin
                    if (i_wb_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_abort_d = 1'b1;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        beat_cnt_d  = '0;
                        in_incr_d   = 1'b0;
                        state_d     = seq_q ? ST_DRAIN : ST_IDLE;
                    end else if (i_wb_ack) begin
                        rsp_valid_d = 1'b1;
                        rsp_abort_d = 1'b0;
                        rsp_data_d  = i_wb_dat;
                        stb_d       = 1'b0;
                        if (seq_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_IDLE;
                            cyc_d   = 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Remaining micro-ops of an aborted sequence never reach the bus.
                    if (accept && !i_req_seq) begin
                        rsp_valid_d = 1'b1;
                        rsp_abort_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            in_incr_q   <= 1'b0;
            seq_q       <= 1'b0;
            beat_q      <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cti_q       <= CTI_CLASSIC;
            rsp_valid_q <= 1'b0;
            rsp_abort_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            in_incr_q   <= in_incr_d;
            seq_q       <= seq_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            cti_q       <= cti_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_abort_q <= rsp_abort_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_abort = rsp_abort_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = beat_q.we;
    assign o_wb_adr    = beat_q.adr;
    assign o_wb_dat    = beat_q.dat;
    assign o_wb_sel    = beat_q.sel;
    assign o_wb_cti    = cti_q;
    assign o_wb_bte    = '0;

endmodule

// File: tb/tb_zap_mem_burst_unit.sv
// Self-checking bench for zap_mem_burst_unit: directed plan items plus randomized sequences.
module tb_zap_mem_burst_unit;

    localparam int unsigned MAXB = 16;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_flush;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_wen;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_ben;
    logic        i_req_seq;
    logic        i_req_incr;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_abort;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic [2:0]  o_wb_cti;
    logic [1:0]  o_wb_bte;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_dat;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_rsp  = 0;
    int   act_rsp  = 0;
    logic model_cyc;

    zap_mem_burst_unit #(.MAX_BEATS(MAXB)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_wen(i_req_wen), .i_req_data(i_req_data),
        .i_req_ben(i_req_ben), .i_req_seq(i_req_seq), .i_req_incr(i_req_incr),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_abort(o_rsp_abort),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_cti(o_wb_cti), .o_wb_bte(o_wb_bte),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Slave read data is a fixed function of the word address.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h3C3C_0000;
    endfunction

    // Incrementing sequences split into bursts of at most MAXB beats; the last
    // beat of each burst is EOB, a one-beat burst is classic. Decrementing is all classic.
    function automatic logic [2:0] model_cti(input logic decr, input int i, input int len);
        int pos, start, blen;
        if (decr) return 3'b000;
        pos   = i % MAXB;
        start = i - pos;
        blen  = ((len - start) < MAXB) ? (len - start) : MAXB;
        if (blen == 1) return 3'b000;
        return (pos == blen - 1) ? 3'b111 : 3'b010;
    endfunction

    task automatic scramble_req();
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        i_req_data  = $urandom;
        i_req_ben   = 4'($urandom_range(0, 15));
        i_req_wen   = 1'($urandom_range(0, 1));
        i_req_seq   = 1'($urandom_range(0, 1));
        i_req_incr  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_beat(input logic [31:0] addr, input logic wen, input logic [3:0] ben,
                           input logic seq, input logic incr, input logic [2:0] exp_cti,
                           input int waits, input logic err, input logic drain);
        logic [31:0] wdata, exp_adr;
        wdata   = $urandom;
        exp_adr = {addr[31:2], 2'b00};
        @(negedge i_clk);
        chk("ready_before_req", 32'(o_req_ready), 1);
        chk("rsp_one_cycle", 32'(o_rsp_valid), 0);
        chk("cyc_before_req", 32'(o_wb_cyc), 32'(model_cyc));
        i_req_valid = 1'b1; i_req_addr = addr; i_req_wen = wen; i_req_data = wdata;
        i_req_ben = ben; i_req_seq = seq; i_req_incr = incr;
        @(negedge i_clk);
        scramble_req();
        if (drain) begin
            chk("drain_cyc", 32'(o_wb_cyc), 0);
            chk("drain_stb", 32'(o_wb_stb), 0);
            chk("drain_rsp_valid", 32'(o_rsp_valid), 32'(!seq));
            if (!seq) begin
                chk("drain_rsp_abort", 32'(o_rsp_abort), 1);
                exp_rsp++;
            end
            model_cyc = 1'b0;
            return;
        end
        chk("beat_cyc", 32'(o_wb_cyc), 1);
        chk("beat_stb", 32'(o_wb_stb), 1);
        chk("beat_ready_low", 32'(o_req_ready), 0);
        chk("beat_adr", o_wb_adr, exp_adr);
        chk("beat_we", 32'(o_wb_we), 32'(wen));
        chk("beat_sel", 32'(o_wb_sel), 32'(ben));
        chk("beat_dat", o_wb_dat, wdata);
        chk("beat_cti", 32'(o_wb_cti), 32'(exp_cti));
        chk("beat_no_rsp", 32'(o_rsp_valid), 0);
        for (int w = 0; w < waits; w++) begin
            @(negedge i_clk);
            chk("wait_stb", 32'(o_wb_stb), 1);
            chk("wait_adr", o_wb_adr, exp_adr);
        end
        i_wb_err = err;
        i_wb_ack = err ? 1'($urandom_range(0, 1)) : 1'b1;
        i_wb_dat = rd_word(exp_adr);
        @(negedge i_clk);
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = $urandom;
        exp_rsp++;
        chk("rsp_valid", 32'(o_rsp_valid), 1);
        chk("rsp_abort", 32'(o_rsp_abort), 32'(err));
        if (!err && !wen) chk("rsp_data", o_rsp_data, rd_word(exp_adr));
        chk("end_stb", 32'(o_wb_stb), 0);
        chk("end_cyc", 32'(o_wb_cyc), 32'(seq && !err));
        chk("end_ready", 32'(o_req_ready), 1);
        model_cyc = seq && !err;
    endtask

    task automatic do_seq(input int len, input logic decr, input logic [31:0] base,
                          input logic wen, input int err_beat);
        logic        drain;
        logic [31:0] a;
        drain = 1'b0;
        for (int i = 0; i < len; i++) begin
            a = decr ? base - 32'(4 * i) : base + 32'(4 * i);
            a[1:0] = 2'($urandom_range(0, 3));
            do_beat(a, wen, 4'($urandom_range(1, 15)), (i != len - 1), !decr,
                    model_cti(decr, i, len), int'($urandom_range(0, 3)), (i == err_beat), drain);
            if (i == err_beat) drain = 1'b1;
        end
    endtask

    // Per-cycle bus invariants and response counting.
    always @(negedge i_clk) begin
        if (o_rsp_valid) act_rsp++;
        chk("wb_bte", 32'(o_wb_bte), 0);
        chk("adr_aligned", 32'(o_wb_adr[1:0]), 0);
        if (!o_wb_cyc) chk("stb_without_cyc", 32'(o_wb_stb), 0);
    end

    initial begin
        logic [2:0] ldm_cti [4];
        ldm_cti = '{3'b010, 3'b010, 3'b010, 3'b111};
        model_cyc = 1'b0;
        i_reset_n = 1'b0; i_flush = 1'b0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = '0;
        scramble_req();
        #3;
        chk("rst_cyc", 32'(o_wb_cyc), 0);
        chk("rst_stb", 32'(o_wb_stb), 0);
        chk("rst_adr", o_wb_adr, 0);
        chk("rst_cti", 32'(o_wb_cti), 0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
        chk("rst_ready", 32'(o_req_ready), 1);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

        // Single store at 0x100, two wait states.
        do_beat(32'h100, 1'b1, 4'hF, 1'b0, 1'b0, 3'b000, 2, 1'b0, 1'b0);
        // LDM of 4 words from 0x200.
        for (int i = 0; i < 4; i++)
            do_beat(32'h200 + 32'(4 * i), 1'b0, 4'hF, (i != 3), 1'b1, ldm_cti[i], 1, 1'b0, 1'b0);
        // Decrementing STM of 3 words.
        for (int i = 0; i < 3; i++)
            do_beat(32'h30C - 32'(4 * i), 1'b1, 4'hF, (i != 2), 1'b0, 3'b000, 0, 1'b0, 1'b0);
        // Error on beat 2 of a 4-beat LDM.
        do_seq(4, 1'b0, 32'h400, 1'b0, 1);
        // 17-beat incrementing sequence.
        for (int i = 0; i < 17; i++)
            do_beat(32'h800 + 32'(4 * i), 1'b0, 4'hF, (i != 16), 1'b1,
                    (i < 15) ? 3'b010 : ((i == 15) ? 3'b111 : 3'b000), 0, 1'b0, 1'b0);

        // Flush while stb is high, late ack the following cycle.
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_addr = 32'h500; i_req_wen = 1'b0; i_req_data = 32'h0;
        i_req_ben = 4'hF; i_req_seq = 1'b1; i_req_incr = 1'b1;
        @(negedge i_clk);
        scramble_req();
        chk("flush_pre_stb", 32'(o_wb_stb), 1);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        chk("flush_cyc", 32'(o_wb_cyc), 0);
        chk("flush_stb", 32'(o_wb_stb), 0);
        chk("flush_rsp", 32'(o_rsp_valid), 0);
        i_wb_ack = 1'b1; i_wb_dat = 32'h1234_5678;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        chk("late_ack_rsp", 32'(o_rsp_valid), 0);
        chk("late_ack_cyc", 32'(o_wb_cyc), 0);
        model_cyc = 1'b0;
        // Beat count must have been cleared by the flush.
        do_beat(32'h700, 1'b0, 4'hF, 1'b0, 1'b0, 3'b000, 1, 1'b0, 1'b0);

        // Asynchronous reset mid-burst.
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_addr = 32'h600; i_req_wen = 1'b1; i_req_data = 32'hDEAD_BEEF;
        i_req_ben = 4'hF; i_req_seq = 1'b1; i_req_incr = 1'b1;
        @(negedge i_clk);
        scramble_req();
        chk("arst_pre_stb", 32'(o_wb_stb), 1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(o_wb_cyc), 0);
        chk("arst_stb", 32'(o_wb_stb), 0);
        chk("arst_we", 32'(o_wb_we), 0);
        chk("arst_adr", o_wb_adr, 0);
        chk("arst_dat", o_wb_dat, 0);
        chk("arst_sel", 32'(o_wb_sel), 0);
        chk("arst_cti", 32'(o_wb_cti), 0);
        chk("arst_rsp_valid", 32'(o_rsp_valid), 0);
        chk("arst_rsp_data", o_rsp_data, 0);
        chk("arst_ready", 32'(o_req_ready), 1);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        model_cyc = 1'b0;

        // Randomized sequences.
        for (int s = 0; s < 60; s++) begin
            int          kind, len, errb;
            logic [31:0] base;
            kind = int'($urandom_range(0, 2));
            len  = (kind == 2) ? 1 : int'($urandom_range(2, 20));
            base = (32'($urandom) & 32'h00FF_FFF0) | 32'h1000_0000;
            errb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            do_seq(len, (kind == 1), base, 1'($urandom_range(0, 1)), errb);
        end

        repeat (3) @(negedge i_clk);
        chk("rsp_count", 32'(act_rsp), 32'(exp_rsp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
